serial_full_adder_ctrl: RTL

- Bit-serial adder stage that drives the team's 1-bit full adder equation ({c1,s} = a0 + a1 + c0) one bit per clock and consumes its sum and carry outputs.
- Loads two WIDTH-bit operands plus carry-in, walks LSB to MSB with a registered carry, and assembles the sum word.
- Sits between operand registers and any consumer needing a multi-bit result from the minimal-area 1-bit adder.

---
 rtl/serial_full_adder_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_full_adder_ctrl.sv
// Bit-serial adder stage: loads two WIDTH-bit operands plus carry-in, then
// feeds one bit per clock through a 1-bit full adder (LSB first), keeping
// the carry in a register and assembling the sum word in a shift register.
module serial_full_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    bit_count;
   logic             carry;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] sum_shift;
   logic             bit_sum;
   logic             bit_carry;
   logic             last_bit;

   assign last_bit = (bit_count == LAST_BIT);

   // One-bit full adder on the current LSBs and the registered carry.
   always_comb begin
      bit_sum   = shift_a[0] ^ shift_b[0] ^ carry;
      bit_carry = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
   end

   // Next-state and status outputs; start is only honoured in IDLE.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; reset abandons any add in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand load, per-bit shifting and result capture on the final bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_a   <= '0;
         shift_b   <= '0;
         sum_shift <= '0;
         carry     <= 1'b0;
         bit_count <= '0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_a   <= a;
                  shift_b   <= b;
                  carry     <= cin;
                  bit_count <= '0;
                  sum_shift <= '0;
               end
            end
            ADD: begin
               shift_a   <= {1'b0, shift_a[WIDTH-1:1]};
               shift_b   <= {1'b0, shift_b[WIDTH-1:1]};
               sum_shift <= {bit_sum, sum_shift[WIDTH-1:1]};
               carry     <= bit_carry;
               if (last_bit) begin
                  sum  <= {bit_sum, sum_shift[WIDTH-1:1]};
                  cout <= bit_carry;
               end else begin
                  bit_count <= bit_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
